// File: rtl/uc_pila_if.sv
// Control-unit bus between the microc datapath and uc_pila: opcode/flag in, datapath
// and return-stack controls out.
interface uc_pila_if #(
    parameter int unsigned OPW  = 6,
    parameter int unsigned ALUW = 3,
    parameter int unsigned SPW  = 3
);
    logic            en;
    logic [OPW-1:0]  opcode;
    logic            z;
    logic            pc_en;
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [ALUW-1:0] op;
    logic            s_push;
    logic            s_pop;
    logic            s_ret;
    logic [SPW-1:0]  sp_level;
    logic            halted;
    logic [1:0]      fault;

    modport master (
        output en, opcode, z,
        input  pc_en, s_inc, s_inm, we3, wez, op, s_push, s_pop, s_ret, sp_level, halted, fault
    );

    modport slave (
        input  en, opcode, z,
        output pc_en, s_inc, s_inm, we3, wez, op, s_push, s_pop, s_ret, sp_level, halted, fault
    );
endinterface

// File: rtl/uc_pila.sv
// Single-cycle microcontroller control unit: opcode decode, call/ret depth tracking,
// halt and sticky fault reporting. Outputs are Mealy and forced to 0 while in reset.
module uc_pila #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned ALUW  = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SPW   = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       reset,
    uc_pila_if.slave  bus
);
    typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

    state_e         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [1:0]     fault_q, fault_d;

    logic [5:0] opc;
    assign opc = bus.opcode[5:0];

    if (OPW > 6) begin : g_opc_hi
        logic unused_opcode_hi;
        assign unused_opcode_hi = ^bus.opcode[OPW-1:6];
    end

    // Decoded controls before stall/state gating
    logic            d_pc_en, d_s_inc, d_s_inm, d_we3, d_wez, d_push, d_pop, d_ret;
    logic [ALUW-1:0] d_op;
    logic            d_halt, d_fault;
    logic [1:0]      d_code;

    always_comb begin
        d_pc_en = 1'b0;
        d_s_inc = 1'b0;
        d_s_inm = 1'b0;
        d_we3   = 1'b0;
        d_wez   = 1'b0;
        d_push  = 1'b0;
        d_pop   = 1'b0;
        d_ret   = 1'b0;
        d_op    = '0;
        d_halt  = 1'b0;
        d_fault = 1'b0;
        d_code  = 2'b00;
        casez (opc)
            6'b0100??: begin
                d_s_inm = 1'b1; d_we3 = 1'b1; d_s_inc = 1'b1; d_pc_en = 1'b1;
            end
            6'b0101??: begin
                d_we3 = 1'b1; d_wez = 1'b1; d_op = ALUW'(3'b010);
                d_s_inc = 1'b1; d_pc_en = 1'b1;
            end
            6'b0110??: begin
                d_we3 = 1'b1; d_wez = 1'b1; d_op = ALUW'(3'b011);
                d_s_inc = 1'b1; d_pc_en = 1'b1;
            end
            6'b1?????: begin
                d_we3 = 1'b1; d_wez = 1'b1; d_op = ALUW'(opc[4:2]);
                d_s_inc = 1'b1; d_pc_en = 1'b1;
            end
            6'b000000: begin
                d_s_inc = 1'b1; d_pc_en = 1'b1;
            end
            6'b000001: d_pc_en = 1'b1;
            6'b000010: begin
                d_s_inc = ~bus.z; d_pc_en = 1'b1;
            end
            6'b000011: begin
                d_s_inc = bus.z; d_pc_en = 1'b1;
            end
            6'b000100: begin
                if (sp_q < SPW'(DEPTH)) begin
                    d_push = 1'b1; d_pc_en = 1'b1;
                end else begin
                    d_fault = 1'b1; d_code = 2'b01;
                end
            end
            6'b000101: begin
                if (sp_q != '0) begin
                    d_pop = 1'b1; d_ret = 1'b1; d_pc_en = 1'b1;
                end else begin
                    d_fault = 1'b1; d_code = 2'b10;
                end
            end
            6'b000110: d_halt = 1'b1;
            default: begin
                d_fault = 1'b1; d_code = 2'b11;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        fault_d      = fault_q;
        bus.pc_en    = 1'b0;
        bus.s_inc    = 1'b0;
        bus.s_inm    = 1'b0;
        bus.we3      = 1'b0;
        bus.wez      = 1'b0;
        bus.op       = '0;
        bus.s_push   = 1'b0;
        bus.s_pop    = 1'b0;
        bus.s_ret    = 1'b0;
        bus.halted   = 1'b0;
        unique case (state_q)
            StRun: begin
                // Mux selects stay visible during a stall; only the enables are gated
                bus.s_inc  = d_s_inc;
                bus.s_inm  = d_s_inm;
                bus.op     = d_op;
                bus.s_ret  = d_ret;
                bus.pc_en  = d_pc_en & bus.en;
                bus.we3    = d_we3 & bus.en;
                bus.wez    = d_wez & bus.en;
                bus.s_push = d_push & bus.en;
                bus.s_pop  = d_pop & bus.en;
                if (bus.en) begin
                    if (d_push) sp_d = sp_q + SPW'(1);
                    if (d_pop)  sp_d = sp_q - SPW'(1);
                    if (d_halt) state_d = StHalt;
                    if (d_fault) begin
                        state_d = StFault;
                        fault_d = d_code;
                    end
                end
            end
            StHalt:  bus.halted = 1'b1;
            default: ;
        endcase
        bus.sp_level = sp_q;
        bus.fault    = fault_q;
        if (!reset) begin
            bus.pc_en    = 1'b0;
            bus.s_inc    = 1'b0;
            bus.s_inm    = 1'b0;
            bus.we3      = 1'b0;
            bus.wez      = 1'b0;
            bus.op       = '0;
            bus.s_push   = 1'b0;
            bus.s_pop    = 1'b0;
            bus.s_ret    = 1'b0;
            bus.halted   = 1'b0;
            bus.sp_level = '0;
            bus.fault    = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            sp_q    <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end
endmodule

// File: tb/tb_uc_pila.sv
// Directed bench for uc_pila: decode, stall, call/ret depth limits, faults, reset, halt.
module tb_uc_pila;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    uc_pila_if #(.OPW(6), .ALUW(3), .SPW(3)) bus ();

    uc_pila #(.OPW(6), .ALUW(3), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] opc, input logic en, input logic z);
        bus.opcode = opc;
        bus.en     = en;
        bus.z      = z;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        bus.opcode = 6'b010011;
        bus.en     = 1'b1;
        bus.z      = 1'b0;
        #1;
        chk("rst_pc_en", bus.pc_en, 0);
        chk("rst_we3", bus.we3, 0);
        chk("rst_sp", bus.sp_level, 0);
        chk("rst_fault", bus.fault, 0);
        tick();
        reset = 1'b1;

        // ldi
        drive(6'b010011, 1'b1, 1'b0);
        chk("ldi_pc_en", bus.pc_en, 1);
        chk("ldi_s_inc", bus.s_inc, 1);
        chk("ldi_s_inm", bus.s_inm, 1);
        chk("ldi_we3", bus.we3, 1);
        chk("ldi_wez", bus.wez, 0);
        chk("ldi_op", bus.op, 0);
        chk("ldi_fault", bus.fault, 0);
        tick();

        // sub, jnz, jz, nop, j
        drive(6'b011001, 1'b1, 1'b0);
        chk("sub_op", bus.op, 3);
        chk("sub_we3", bus.we3, 1);
        chk("sub_wez", bus.wez, 1);
        tick();
        drive(6'b000011, 1'b1, 1'b0);
        chk("jnz_z0_s_inc", bus.s_inc, 0);
        chk("jnz_z0_pc_en", bus.pc_en, 1);
        tick();
        drive(6'b000011, 1'b1, 1'b1);
        chk("jnz_z1_s_inc", bus.s_inc, 1);
        tick();
        drive(6'b000010, 1'b1, 1'b1);
        chk("jz_z1_s_inc", bus.s_inc, 0);
        tick();
        drive(6'b000001, 1'b1, 1'b0);
        chk("j_s_inc", bus.s_inc, 0);
        chk("j_pc_en", bus.pc_en, 1);
        tick();
        drive(6'b000000, 1'b1, 1'b0);
        chk("nop_s_inc", bus.s_inc, 1);
        chk("nop_we3", bus.we3, 0);
        tick();
        drive(6'b010101, 1'b1, 1'b0);
        chk("add_op", bus.op, 2);
        tick();

        // generic ALU, then stalled
        drive(6'b110100, 1'b1, 1'b0);
        chk("alu_op", bus.op, 5);
        chk("alu_we3", bus.we3, 1);
        chk("alu_wez", bus.wez, 1);
        tick();
        drive(6'b110100, 1'b0, 1'b0);
        chk("stall_we3", bus.we3, 0);
        chk("stall_wez", bus.wez, 0);
        chk("stall_pc_en", bus.pc_en, 0);
        chk("stall_op", bus.op, 5);
        chk("stall_s_inc", bus.s_inc, 1);
        tick();

        // stalled call leaves sp alone
        drive(6'b000100, 1'b0, 1'b0);
        chk("stall_call_push", bus.s_push, 0);
        tick();
        chk("stall_call_sp", bus.sp_level, 0);

        // fill the return stack, then overflow
        for (int i = 1; i <= 4; i++) begin
            drive(6'b000100, 1'b1, 1'b0);
            chk($sformatf("call%0d_push", i), bus.s_push, 1);
            chk($sformatf("call%0d_s_inc", i), bus.s_inc, 0);
            tick();
            chk($sformatf("call%0d_sp", i), bus.sp_level, i);
        end
        drive(6'b000100, 1'b1, 1'b0);
        chk("call5_push", bus.s_push, 0);
        chk("call5_pc_en", bus.pc_en, 0);
        tick();
        chk("ovf_fault", bus.fault, 1);
        drive(6'b000101, 1'b1, 1'b0);
        chk("ovf_ret_pop", bus.s_pop, 0);
        chk("ovf_ret_pc_en", bus.pc_en, 0);
        tick();
        chk("ovf_ret_sp", bus.sp_level, 4);
        chk("ovf_sticky", bus.fault, 1);
        chk("ovf_halted", bus.halted, 0);

        // underflow
        do_reset();
        chk("reset_sp", bus.sp_level, 0);
        drive(6'b000101, 1'b1, 1'b0);
        chk("udf_pop", bus.s_pop, 0);
        chk("udf_pc_en", bus.pc_en, 0);
        tick();
        chk("udf_fault", bus.fault, 2);
        drive(6'b001111, 1'b1, 1'b0);
        tick();
        chk("udf_sticky", bus.fault, 2);

        // illegal opcode
        do_reset();
        drive(6'b001111, 1'b1, 1'b0);
        chk("ill_pc_en", bus.pc_en, 0);
        chk("ill_we3", bus.we3, 0);
        tick();
        chk("ill_fault", bus.fault, 3);

        // calls, a return, then reset in mid-cycle
        do_reset();
        drive(6'b000100, 1'b1, 1'b0);
        tick();
        drive(6'b000100, 1'b1, 1'b0);
        tick();
        chk("two_calls_sp", bus.sp_level, 2);
        drive(6'b000101, 1'b1, 1'b0);
        chk("ret_pop", bus.s_pop, 1);
        chk("ret_s_ret", bus.s_ret, 1);
        chk("ret_pc_en", bus.pc_en, 1);
        tick();
        chk("ret_sp", bus.sp_level, 1);
        drive(6'b000100, 1'b1, 1'b0);
        tick();
        chk("recall_sp", bus.sp_level, 2);
        drive(6'b000100, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_sp", bus.sp_level, 0);
        chk("midrst_push", bus.s_push, 0);
        chk("midrst_pc_en", bus.pc_en, 0);
        chk("midrst_s_inc", bus.s_inc, 0);
        reset = 1'b1;
        #1;
        chk("after_rst_sp", bus.sp_level, 0);

        // halt, then stays halted regardless of en/opcode
        drive(6'b000110, 1'b1, 1'b0);
        chk("halt_pc_en", bus.pc_en, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(6'b010011, i[0], 1'b0);
            chk($sformatf("halt%0d_halted", i), bus.halted, 1);
            chk($sformatf("halt%0d_pc_en", i), bus.pc_en, 0);
            chk($sformatf("halt%0d_we3", i), bus.we3, 0);
            tick();
        end
        chk("halt_fault", bus.fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uc_pila.md
Name: uc_pila

Overview:
- Parametrised control unit for the single-cycle microcontroller datapath. It supersedes the behavioural opcode decoder used in the microc bench.
- Decodes the opcode into datapath controls: s_inc, s_inm, we3, wez and op.
- Adds a generic ALU opcode class, jz and jnz, call/ret through a return-stack depth tracker, halt, a stall input and sticky fault reporting.
- Sits between microc's opcode/z outputs and its control inputs. It drives an external return-address stack via s_push, s_pop and s_ret.

Parameters:
- OPW, 6, opcode width; must be ≥6, decoding uses opcode[5:0] and ignores upper bits.
- ALUW, 3, ALU op width.
- DEPTH, 4, return-stack capacity; must be ≥1.
- SPW, $clog2(DEPTH+1), width of sp_level.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  advance enable; 0 = stall.
- opcode  in  OPW  current instruction opcode.
- z  in  1  zero flag from datapath.
- pc_en  out  1  PC load enable.
- s_inc  out  1  1 = PC+1, 0 = jump target.
- s_inm  out  1  register-file write data from immediate.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- op  out  ALUW  ALU operation.
- s_push  out  1  push PC+1 onto the return stack.
- s_pop  out  1  pop the return stack.
- s_ret  out  1  PC source = stack top (overrides s_inc).
- sp_level  out  SPW  current stack occupancy.
- halted  out  1  in HALT.
- fault  out  2  fault code: 00 none, 01 overflow, 10 underflow, 11 illegal opcode.

Behaviour:
- State: FSM {RUN, HALT, FAULT}, sp counter and fault register, all clocked on the rising edge of clk.
- Reset (reset=0, asynchronous): state=RUN, sp=0, fault=00.
- Outputs are combinational (Mealy) from state, opcode, z and sp. While reset=0, every output is 0, including sp_level.
- RUN with en=1, decode on opcode[5:0] (x = don't care):
  - 0100xx ldi: s_inm=1, we3=1, s_inc=1, pc_en=1.
  - 0101xx add: we3=1, wez=1, op=010, s_inc=1, pc_en=1.
  - 0110xx sub: we3=1, wez=1, op=011, s_inc=1, pc_en=1.
  - 1ooo xx generic ALU: op=opcode[4:2] zero-extended to ALUW; we3=1, wez=1, s_inc=1, pc_en=1.
  - 000000 nop: s_inc=1, pc_en=1.
  - 000001 j: s_inc=0, pc_en=1.
  - 000010 jz: s_inc=~z, pc_en=1.
  - 000011 jnz: s_inc=z, pc_en=1.
  - 000100 call: if sp<DEPTH then s_push=1, s_inc=0, pc_en=1, sp increments. Else all enables 0, next state FAULT, fault=01.
  - 000101 ret: if sp>0 then s_pop=1, s_ret=1, pc_en=1, sp decrements. Else all enables 0, next state FAULT, fault=10.
  - 000110 halt: all enables 0, next state HALT.
  - Any other code: all enables 0, next state FAULT, fault=11.
  - Outputs not listed for an opcode are 0.
- RUN with en=0: pc_en, we3, wez, s_push and s_pop are 0. sp and state hold; s_inc, s_inm and op still show the decoded values.
- HALT: all enables 0, halted=1. Stays in HALT until reset; en is ignored.
- FAULT: all enables 0. fault holds the first code recorded (sticky). Stays in FAULT until reset.
- sp never wraps. sp and fault update only on cycles with en=1.
- Reset asserted mid-call: sp returns to 0 immediately; the external stack contents are thereafter treated as empty.

Test Plan:
- Reset, then opcode=010011 (ldi), en=1 → pc_en=1, s_inc=1, s_inm=1, we3=1, wez=0, op=000 in the same cycle; fault=00.
- opcode=011001 (sub) then 000011 (jnz) with z=0 → sub: op=011, we3=1, wez=1. jnz with z=0: s_inc=0. Repeat jnz with z=1 → s_inc=1.
- opcode=110100 (generic ALU) → op=101, we3=1, wez=1. Drive en=0 for the same opcode → we3=0, wez=0, pc_en=0, op stays 101.
- DEPTH=4: five consecutive calls → sp_level goes 1, 2, 3, 4. The fifth call gives s_push=0, then fault=01 and FAULT state. A following ret is ignored and sp_level stays 4.
- After reset, ret → fault=10, s_pop=0. Separately, opcode=001111 → fault=11.
- Two calls, then reset pulled low mid-cycle → all outputs 0 and sp_level=0 immediately. After release, halt (000110) → halted=1 and all enables 0 for the next 10 cycles.
